mat_mul_pipe: RTL and testbench
===============================

MAT_MUL_PIPE -- requirements
Module: mat_mul_pipe

Interface
REQ-001 Parameter DW, default 8, element width of input matrix entries, 2..16.
REQ-002 Parameter SIGNED, default 0; 0 means operands and results are unsigned, 1 means two's complement.
REQ-003 Derived width OW = 2*DW, the result element width; not overridable.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  x_mat/y_mat hold a valid operand pair.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 x_mat  input  4*DW  matrix X, packed {x11,x10,x01,x00}, x00 in the LSBs.
REQ-009 y_mat  input  4*DW  matrix Y, packed {y11,y10,y01,y00}.
REQ-010 out_valid  output  1  z_mat holds a valid result.
REQ-011 out_ready  input  1  downstream consumes z_mat this cycle.
REQ-012 z_mat  output  4*OW  result Z = X*Y, packed {z11,z10,z01,z00}.
REQ-013 in_flight  output  2  count of results held in the pipeline, 0..2.

Function
REQ-014 zij SHALL equal xi0*y0j + xi1*y1j.
- Products use full OW bits.
- The sum is formed at OW+1 bits and reduced to OW bits per REQ-030/031.
REQ-015 Stage 1 SHALL register the eight products and a valid bit s1_valid.
REQ-016 Stage 2 SHALL register the four sums into z_mat with valid bit out_valid.
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-018 Stage 2 load enable is ld2 = !out_valid || out_ready; stage 2 captures s1 contents and s1_valid when ld2.
REQ-019 in_ready SHALL be !s1_valid || ld2, combinational, with no dependence on in_valid.
REQ-020 Stage 1 load enable is ld1 = in_ready.
- On ld1, stage 1 captures products and sets s1_valid = in_valid.
- Otherwise stage 1 holds.
REQ-021 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput is 1 result per cycle.
REQ-022 While out_valid && !out_ready, z_mat and out_valid SHALL hold stable.
REQ-023 No accepted operand pair SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 Results SHALL exit in acceptance order.
REQ-025 in_flight SHALL equal s1_valid + out_valid, registered consistently with those bits.
REQ-026 Simultaneous input and output transfer with both stages full SHALL keep in_flight at 2.
REQ-027 X or Y lanes SHALL be ignored when in_valid is low; stage registers with valid=0 carry don't-care data.

Reset
REQ-028 When rst is high at a clock edge, s1_valid, out_valid and in_flight SHALL go 0; z_mat SHALL go 0 and stage-1 products SHALL go 0.
REQ-029 rst SHALL take priority over any transfer in the same cycle.
- In-flight results are discarded.
- in_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With macro MAT_MUL_OUT_SAT_EN defined, each zij SHALL clamp to the OW-bit range.
- Unsigned range is 0..2^OW-1.
- Signed range is -2^(OW-1)..2^(OW-1)-1.
REQ-031 Without MAT_MUL_OUT_SAT_EN, each zij SHALL be the low OW bits of the exact sum, i.e. modulo 2^OW wrap; no saturation logic is present.

Verification
REQ-032 DW=8, SIGNED=0; X=[[1,2],[3,4]], Y=[[5,6],[7,8]] -> out_valid 2 cycles later, Z=[[19,22],[43,50]].
REQ-033 DW=8, SIGNED=0; all elements 255 -> each zij = 64514 (0xFC02) without SAT_EN, 65535 with SAT_EN.
REQ-034 DW=8, SIGNED=1; all elements -128 -> each zij = 0x8000 without SAT_EN, 0x7FFF (32767) with SAT_EN.
REQ-035 Backpressure test: out_ready=0, in_valid=1 for 4 cycles with distinct X.
- Exactly 2 pairs are accepted, in_ready=0 thereafter, in_flight=2.
- After out_ready=1, results emerge in order with none lost.
REQ-036 Streaming test: 10 back-to-back pairs with out_ready=1 -> 10 consecutive out_valid cycles, first at cycle +2.
REQ-037 Reset test: rst pulsed with in_flight=2 -> next cycle out_valid=0, in_flight=0, in_ready=1, z_mat=0, and no stale result appears afterward.

Source files
------------

// File: rtl/mat_mul_pipe.sv
// mat_mul_pipe: 2x2 matrix multiplier Z = X*Y with two register stages and
// valid/ready handshakes on both sides.
//   Stage 1: the eight element products plus s1_valid.
//   Stage 2: the four sums (z_mat) plus out_valid.
// Optional feature macro: MAT_MUL_OUT_SAT_EN clamps each result element to the
// OW-bit range. Without it, each element wraps modulo 2^OW.
module mat_mul_pipe #(
  parameter int DW     = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*DW-1:0] x_mat,
  input  logic [4*DW-1:0] y_mat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] z_mat,
  output logic [1:0]      in_flight
);

  localparam int OW = 2 * DW;

  logic          s1_valid;
  logic          ld1, ld2;
  logic          s1_valid_n, out_valid_n;
  logic [OW-1:0] prod    [8];
  logic [OW-1:0] s1_prod [8];
  logic [8*DW-1:0] z_n;

  // Extend an operand to OW bits so that the low OW bits of the product are
  // exact in both signed and unsigned modes.
  function automatic logic [OW-1:0] ext_op(input logic [DW-1:0] a);
    return SIGNED ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
  endfunction

  // Handshake: stage 2 loads when empty or drained, and stage 1 loads when
  // it is empty or its contents move on to stage 2.
  always_comb begin
    ld2         = !out_valid || out_ready;
    in_ready    = !s1_valid || ld2;
    ld1         = in_ready;
    s1_valid_n  = ld1 ? in_valid : s1_valid;
    out_valid_n = ld2 ? s1_valid : out_valid;
  end

  // Element products. prod[(2*i+j)*2+k] = x[i][k] * y[k][j].
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        for (int unsigned k = 0; k < 2; k++) begin
          prod[(2*i+j)*2+k] = ext_op(x_mat[(2*i+k)*DW +: DW]) *
                              ext_op(y_mat[(2*k+j)*DW +: DW]);
        end
      end
    end
  end

  // Sum each pair of products into a result element, then wrap or clamp it.
  always_comb begin
    z_n = '0;
    for (int unsigned e = 0; e < 4; e++) begin
`ifdef MAT_MUL_OUT_SAT_EN
      logic [OW:0] s;
      if (SIGNED) begin
        s = {s1_prod[2*e][OW-1], s1_prod[2*e]} + {s1_prod[2*e+1][OW-1], s1_prod[2*e+1]};
        // The sum has overflowed when its top two bits differ. The top bit
        // then gives the true sign, which selects the clamp value.
        if (s[OW] != s[OW-1]) begin
          z_n[e*OW +: OW] = s[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
          z_n[e*OW +: OW] = s[OW-1:0];
        end
      end else begin
        s = {1'b0, s1_prod[2*e]} + {1'b0, s1_prod[2*e+1]};
        z_n[e*OW +: OW] = s[OW] ? '1 : s[OW-1:0];
      end
`else
      z_n[e*OW +: OW] = s1_prod[2*e] + s1_prod[2*e+1];
`endif
    end
  end

  // Pipeline registers. Reset clears everything and overrides any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      in_flight <= '0;
      z_mat     <= '0;
      s1_prod   <= '{default: '0};
    end else begin
      s1_valid  <= s1_valid_n;
      out_valid <= out_valid_n;
      in_flight <= {1'b0, s1_valid_n} + {1'b0, out_valid_n};
      if (ld1) s1_prod <= prod;
      if (ld2) z_mat   <= z_n;
    end
  end

endmodule

// File: tb/tb_mat_mul_pipe.sv
// Self-checking bench for mat_mul_pipe: an unsigned and a signed instance
// share the stimulus, and a queue-based reference model checks both.
module tb_mat_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x_mat = '0;
  logic [31:0] y_mat = '0;

  logic        in_ready, out_valid;
  logic [63:0] z_u;
  logic [1:0]  in_flight;
  logic        in_ready_s, out_valid_s;
  logic [63:0] z_s;
  logic [1:0]  in_flight_s;

  int checks = 0;
  int errors = 0;
  int acc    = 0;
  logic [63:0] qu[$];
  logic [63:0] qs[$];
  bit          prev_stall = 1'b0;
  logic [63:0] prev_z = '0;

  always #5 clk = ~clk;

  mat_mul_pipe #(.DW(8), .SIGNED(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_mat(x_mat), .y_mat(y_mat), .out_valid(out_valid), .out_ready(out_ready),
    .z_mat(z_u), .in_flight(in_flight)
  );

  mat_mul_pipe #(.DW(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .x_mat(x_mat), .y_mat(y_mat), .out_valid(out_valid_s), .out_ready(out_ready),
    .z_mat(z_s), .in_flight(in_flight_s)
  );

  function automatic longint el(input logic [31:0] m, input int idx, input bit sgn);
    logic [7:0] b;
    b = m[idx*8 +: 8];
    if (sgn) return longint'($signed(b));
    return longint'(b);
  endfunction

  // Reference: zij = xi0*y0j + xi1*y1j, then clamped or wrapped to 16 bits.
  function automatic logic [63:0] ref_z(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    logic [63:0] z;
    longint s;
    z = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = el(x, 2*i, sgn) * el(y, j, sgn) + el(x, 2*i+1, sgn) * el(y, 2+j, sgn);
`ifdef MAT_MUL_OUT_SAT_EN
        if (sgn) begin
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
        end else if (s > 65535) begin
          s = 65535;
        end
`endif
        z[(2*i+j)*16 +: 16] = s[15:0];
      end
    end
    return z;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the handshake state against the model at the falling
  // edge, record the transfers that the next rising edge will perform, and
  // return 1 time unit after that edge.
  task automatic cycle();
    logic exp_ready;
    @(negedge clk);
    if (rst) begin
      qu.delete();
      qs.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_flight", in_flight, qu.size());
      chk("in_flight_s", in_flight_s, qs.size());
      exp_ready = (qu.size() == 2 && !out_ready) ? 1'b0 : 1'b1;
      chk("in_ready", in_ready, exp_ready);
      exp_ready = (qs.size() == 2 && !out_ready) ? 1'b0 : 1'b1;
      chk("in_ready_s", in_ready_s, exp_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_z", z_u, prev_z);
      end
      prev_stall = out_valid && !out_ready;
      prev_z     = z_u;
      if (out_valid && out_ready) begin
        if (qu.size() == 0) chk("spurious_out", out_valid, 0);
        else chk("z_u", z_u, qu.pop_front());
      end
      if (out_valid_s && out_ready) begin
        if (qs.size() == 0) chk("spurious_out_s", out_valid_s, 0);
        else chk("z_s", z_s, qs.pop_front());
      end
      if (in_valid && in_ready) begin
        qu.push_back(ref_z(x_mat, y_mat, 1'b0));
        acc++;
      end
      if (in_valid && in_ready_s) qs.push_back(ref_z(x_mat, y_mat, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && (qu.size() > 0 || qs.size() > 0); n++) cycle();
    chk(tag, qu.size() + qs.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted while a pair is offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    x_mat = $urandom; y_mat = $urandom;
    cycle(); cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_z", z_u, 0);
    chk("rst_z_s", z_s, 0);

    // Basic product with two-cycle latency.
    x_mat = 32'h04030201; y_mat = 32'h08070605; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_s1_only", out_valid, 0);
    cycle();
    chk("lat_out_valid", out_valid, 1);
    chk("z_basic", z_u, 64'h0032_002B_0016_0013);
    cycle();

    // All elements 255 (unsigned) / -1 (signed).
    x_mat = '1; y_mat = '1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
`ifdef MAT_MUL_OUT_SAT_EN
    chk("z_max_u", z_u, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("z_max_u", z_u, 64'hFC02_FC02_FC02_FC02);
`endif
    cycle();

    // All elements 0x80: -128 in the signed instance overflows the sum.
    x_mat = 32'h80808080; y_mat = 32'h80808080; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("z_128_u", z_u, 64'h8000_8000_8000_8000);
`ifdef MAT_MUL_OUT_SAT_EN
    chk("z_min_s", z_s, 64'h7FFF_7FFF_7FFF_7FFF);
`else
    chk("z_min_s", z_s, 64'h8000_8000_8000_8000);
`endif
    cycle();

    // Backpressure: four offered pairs, only two fit.
    out_ready = 1'b0; acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      x_mat = 32'h11111111 * (k + 1);
      y_mat = $urandom;
      cycle();
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_in_flight", in_flight, 2);

    // Both stages full with simultaneous input and output transfer.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      x_mat = $urandom; y_mat = $urandom;
      cycle();
      chk("flow_in_flight", in_flight, 2);
    end
    drain("bp_drain");

    // Streaming: ten back-to-back pairs, outputs on cycles +2..+11.
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < 10);
      x_mat = $urandom; y_mat = $urandom;
      cycle();
      chk("stream_out_valid", out_valid, (k >= 1 && k <= 10) ? 1 : 0);
    end

    // Reset with two results in flight: they must be discarded.
    out_ready = 1'b0; in_valid = 1'b1;
    x_mat = $urandom; y_mat = $urandom;
    cycle();
    x_mat = $urandom;
    cycle();
    chk("pre_rst_in_flight", in_flight, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_flight", in_flight, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_z", z_u, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("no_stale", out_valid, 0);
    end

    // Random traffic and random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      x_mat = $urandom; y_mat = $urandom;
      cycle();
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
